keypad_scanner: RTL

- Input-side counterpart to the scanned seven-segment display path: actively scans a 4x4 hex keypad (Pmod KYPD style).
- Drives one column low at a time and samples the active-low rows.
- Debounces across full scans and emits a 4-bit hex key code with a one-cycle valid strobe.
- Sits between the board keypad pins and the operand/math logic, as a keypad alternative to the sw[7:0] operands.

---
 rtl/keypad_scanner.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Actively scans a 4x4 hex keypad: one column is driven low at a time, the
// active-low rows are synchronized and sampled at the end of each column's
// dwell, and a full four-column scan produces a single result (first pressed
// key in column-then-row order, or "none"). Results are debounced across
// DEBOUNCE_SCANS consecutive identical scans before a press or release is
// accepted.
//
// Ports:
//   clock     - board clock
//   reset     - asynchronous active-low reset
//   row[3:0]  - keypad rows, active-low, asynchronous to clock
//   col[3:0]  - keypad column drive, active-low, exactly one bit low
//   key[3:0]  - hex code of the last accepted key (held after release)
//   key_valid - one-cycle pulse when a new press is accepted
//   key_held  - high while the accepted key remains (debounced) pressed
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // Physical keypad layout: column c, row r (top to bottom) -> hex code.
    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h4;
            4'h2:    code = 4'h7;
            4'h3:    code = 4'h0;
            4'h4:    code = 4'h2;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h8;
            4'h7:    code = 4'hF;
            4'h8:    code = 4'h3;
            4'h9:    code = 4'h6;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hE;
            4'hC:    code = 4'hA;
            4'hD:    code = 4'hB;
            4'hE:    code = 4'hC;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_r;
    logic [3:0]    row_sync_r;
    logic [DW-1:0] dwell_cnt_r;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_r;
    logic          acc_hit_r;
    logic [3:0]    acc_code_r;

    logic          cand_hit_r;
    logic [3:0]    cand_code_r;
    logic [CW-1:0] cand_cnt_r;
    state_t        state_r;
    logic [3:0]    stable_code_r;
    logic [3:0]    key_r;
    logic          key_valid_r;
    logic          key_held_r;

    logic          col_hit_s;
    logic [1:0]    col_row_s;
    logic          scan_hit_s;
    logic [3:0]    scan_code_s;
    logic          sample_s;
    logic          scan_end_s;
    logic          match_s;
    logic [CW-1:0] next_cnt_s;
    logic          accept_s;
    logic          press_s;
    logic          release_s;

    assign sample_s   = (dwell_cnt_r == DWELL_LAST);
    assign scan_end_s = sample_s && (col_idx_r == 2'd3);

    // Priority encode the sampled rows of the current column, row0 first.
    always_comb begin
        col_hit_s = 1'b0;
        col_row_s = 2'd0;
        if (!row_sync_r[0]) begin
            col_hit_s = 1'b1;
            col_row_s = 2'd0;
        end else if (!row_sync_r[1]) begin
            col_hit_s = 1'b1;
            col_row_s = 2'd1;
        end else if (!row_sync_r[2]) begin
            col_hit_s = 1'b1;
            col_row_s = 2'd2;
        end else if (!row_sync_r[3]) begin
            col_hit_s = 1'b1;
            col_row_s = 2'd3;
        end else begin
            col_hit_s = 1'b0;
            col_row_s = 2'd0;
        end
    end

    // Merge this column into the running scan result; earlier columns win.
    always_comb begin
        scan_hit_s  = col_hit_s;
        scan_code_s = key_code(col_idx_r, col_row_s);
        if ((col_idx_r != 2'd0) && acc_hit_r) begin
            scan_hit_s  = 1'b1;
            scan_code_s = acc_code_r;
        end else begin
            scan_hit_s  = col_hit_s;
            scan_code_s = key_code(col_idx_r, col_row_s);
        end
    end

    // Debounce decision for the scan ending this cycle; the candidate always
    // becomes the new scan result, only the count depends on the match.
    always_comb begin
        match_s    = (scan_hit_s == cand_hit_r) &&
                     (!scan_hit_s || (scan_code_s == cand_code_r));
        next_cnt_s = CW'(1);
        if (match_s) begin
            if (cand_cnt_r == DB_TARGET) begin
                next_cnt_s = DB_TARGET;
            end else begin
                next_cnt_s = cand_cnt_r + CW'(1);
            end
        end else begin
            next_cnt_s = CW'(1);
        end
        accept_s  = (next_cnt_s == DB_TARGET);
        press_s   = accept_s && scan_hit_s &&
                    ((state_r == ST_IDLE) || (scan_code_s != stable_code_r));
        release_s = accept_s && !scan_hit_s && (state_r == ST_PRESSED);
    end

    // Row synchronizer, dwell counter, column rotation and scan accumulation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_r  <= 4'hF;
            row_sync_r  <= 4'hF;
            dwell_cnt_r <= '0;
            col_idx_r   <= 2'd0;
            col_r       <= 4'b1110;
            acc_hit_r   <= 1'b0;
            acc_code_r  <= 4'h0;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
            if (sample_s) begin
                dwell_cnt_r <= '0;
                col_idx_r   <= col_idx_r + 2'd1;
                col_r       <= {col_r[2:0], col_r[3]};
                acc_hit_r   <= scan_hit_s;
                acc_code_r  <= scan_code_s;
            end else begin
                dwell_cnt_r <= dwell_cnt_r + DW'(1);
            end
        end
    end

    // Debounce state and press/release FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand_hit_r    <= 1'b0;
            cand_code_r   <= 4'h0;
            cand_cnt_r    <= '0;
            state_r       <= ST_IDLE;
            stable_code_r <= 4'h0;
            key_r         <= 4'h0;
            key_valid_r   <= 1'b0;
            key_held_r    <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (scan_end_s) begin
                cand_hit_r  <= scan_hit_s;
                cand_code_r <= scan_code_s;
                cand_cnt_r  <= next_cnt_s;
                case (state_r)
                    ST_IDLE: begin
                        if (press_s) begin
                            state_r       <= ST_PRESSED;
                            stable_code_r <= scan_code_s;
                            key_r         <= scan_code_s;
                            key_valid_r   <= 1'b1;
                            key_held_r    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (press_s) begin
                            // Direct change to another key counts as a new press.
                            stable_code_r <= scan_code_s;
                            key_r         <= scan_code_s;
                            key_valid_r   <= 1'b1;
                        end else if (release_s) begin
                            state_r    <= ST_IDLE;
                            key_held_r <= 1'b0;
                        end else begin
                            state_r <= ST_PRESSED;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        key_held_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign col       = col_r;
    assign key       = key_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule
